median_filter: RTL and testbench
================================

// Module: median_filter
// PURPOSE
//   3x3 median filter on an 8-bit grayscale stream with valid/hsync/vsync framing.
//   Sits directly upstream of the sobel edge stage: its median/median_valid/median_hsync/median_vsync
//   outputs drive sobel's inputs 1:1. Removes salt-and-pepper noise before gradient detection.
//   Fixed 4-cycle latency; pipelined sorting network, one pixel per clock.
// PARAMETERS
//   DATA_WIDTH    8   grayscale channel width
//   BORDER_VALUE  0   value emitted for border pixels (first 2 rows / first 2 pixels of each line)
// PORTS
//   clk           in   1           single clock, all logic on rising edge
//   reset_p       in   1           synchronous, active-high reset
//   gray          in   DATA_WIDTH  input grayscale pixel
//   gray_valid    in   1           pixel valid
//   gray_hsync    in   1           line active (high during a line)
//   gray_vsync    in   1           frame active (high during a frame)
//   median        out  DATA_WIDTH  filtered pixel
//   median_valid  out  1           gray_valid delayed 4 clk
//   median_hsync  out  1           gray_hsync delayed 4 clk
//   median_vsync  out  1           gray_vsync delayed 4 clk
// BEHAVIOUR
//   Reset: synchronous, active-high; only one clock.
//     - On reset: all outputs = 0, window regs = 0, pipeline regs = 0, counters = 0.
//     - Line-buffer RAM contents are not reset.
//   Line buffer: shift_register_2taps, written when gray_valid.
//     - taps0x = row above-above; taps1x = row above; gray = current row.
//   Window (cycle 1):
//     - When vsync&&hsync&&valid: shift the 3x3 window left, loading col2 from taps0x/taps1x/gray.
//     - When vsync&&hsync&&!valid: hold the window.
//     - When !(vsync&&hsync): clear the window to 0.
//   Border counters (2-bit, saturating at 2):
//     - col_cnt: +1 per accepted pixel; cleared while hsync low.
//     - row_cnt: +1 on each hsync falling edge while vsync high; cleared while vsync low.
//     - border = (row_cnt<2)||(col_cnt<2), sampled at the window stage and piped alongside the data.
//   Sort stage A (cycle 2): each window row sorted into {max,mid,min}.
//   Sort stage B (cycle 3):
//     - max_of_mins = max(3 mins); med_of_mids = med(3 mids); min_of_maxes = min(3 maxes).
//   Stage C (cycle 4): median = border ? BORDER_VALUE : med(max_of_mins, med_of_mids, min_of_maxes).
//   Sort stages advance every clock (free-running).
//     - While valid is low the output data is stale but stable; consumers qualify it with median_valid.
//   Control: valid/hsync/vsync each pass through a 4-deep shift register; median is aligned with median_valid.
//   Comparisons are unsigned, DATA_WIDTH wide; ties resolve to either input (results are equal); no width growth.
//   Valid while hsync or vsync is low: the pixel is not loaded into the window; valid is still delayed to the output.
//   Reset asserted mid-frame: output is 0 on the next edge. After release, the first frame resumes border
//     handling from row_cnt=0; a partial frame after reset is not guaranteed correct until the next vsync.
//   No backpressure: the consumer must accept one pixel per clock.
// STRUCTURE
//   Shared include median_defs.vh:
//     - MEDIAN_LATENCY = 4
//     - 3-input compare-swap macros / function sort3_f (max, mid, min)
//   Sub-module sort3: registered 3-input sorter (in a,b,c -> out max,mid,min).
//     - Instantiated 3x in stage A; reused for stage B/C via its outputs.
//   Reuses the existing shift_register_2taps line buffer; no other new sub-modules.
// TESTING
//   Flat image 100, 16x8 frame -> interior median=100; rows 0-1 and cols 0-1 = 0; valid 4 clk after input.
//   Single 255 impulse at (5,4) in a zero field -> every median output = 0 (impulse removed).
//   Window [10,200,30; 40,50,60; 70,80,90] -> median output = 60.
//   gray_valid toggling 1-0-1 inside a line -> window holds; outputs match the gap-free run, shifted in time.
//   reset_p pulsed for 1 clk mid-line -> next edge: all outputs 0; the next full frame matches the golden model.
//   Back-to-back frames, vsync low 3 clk between -> row_cnt restarts; frame 2 border rows = BORDER_VALUE.

Source files
------------

// File: rtl/median_filter_pkg.sv
// rtl/median_filter_pkg.sv - shared constants and 3-input compare helpers for the median filter
package median_filter_pkg;

    // Pipeline depth from input sample to median output
    localparam int MEDIAN_LATENCY = 4;

    // Helpers work on a wide unsigned word; callers zero-extend in and truncate out
    localparam int SORT_WIDTH = 32;

    typedef logic [SORT_WIDTH-1:0] sort_word_t;

    function automatic sort_word_t max3_f(input sort_word_t a, input sort_word_t b, input sort_word_t c);
        sort_word_t hi_ab;
        hi_ab = (a > b) ? a : b;
        return (hi_ab > c) ? hi_ab : c;
    endfunction

    function automatic sort_word_t min3_f(input sort_word_t a, input sort_word_t b, input sort_word_t c);
        sort_word_t lo_ab;
        lo_ab = (a > b) ? b : a;
        return (lo_ab < c) ? lo_ab : c;
    endfunction

    function automatic sort_word_t med3_f(input sort_word_t a, input sort_word_t b, input sort_word_t c);
        sort_word_t hi_ab;
        sort_word_t lo_ab;
        hi_ab = (a > b) ? a : b;
        lo_ab = (a > b) ? b : a;
        if (c > hi_ab) begin
            return hi_ab;
        end else if (c < lo_ab) begin
            return lo_ab;
        end
        return c;
    endfunction

endpackage

// File: rtl/median_filter_sort3.sv
// rtl/median_filter_sort3.sv - registered 3-input sorter producing max, mid and min
module median_filter_sort3
    import median_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    output logic [DATA_WIDTH-1:0] max_v,
    output logic [DATA_WIDTH-1:0] mid_v,
    output logic [DATA_WIDTH-1:0] min_v
);

    // Sort the three inputs and register the ordered result
    always_ff @(posedge clk) begin
        if (reset_p) begin
            max_v <= '0;
            mid_v <= '0;
            min_v <= '0;
        end else begin
            max_v <= DATA_WIDTH'(max3_f(SORT_WIDTH'(a), SORT_WIDTH'(b), SORT_WIDTH'(c)));
            mid_v <= DATA_WIDTH'(med3_f(SORT_WIDTH'(a), SORT_WIDTH'(b), SORT_WIDTH'(c)));
            min_v <= DATA_WIDTH'(min3_f(SORT_WIDTH'(a), SORT_WIDTH'(b), SORT_WIDTH'(c)));
        end
    end

endmodule

// File: rtl/shift_register_2taps.sv
// rtl/shift_register_2taps.sv - two-line pixel delay buffer with one tap per line
module shift_register_2taps #(
    parameter int DATA_WIDTH   = 8,
    parameter int TAP_DISTANCE = 640
) (
    input  logic                  clk,
    input  logic                  clken,
    input  logic [DATA_WIDTH-1:0] shiftin,
    output logic [DATA_WIDTH-1:0] taps0x,
    output logic [DATA_WIDTH-1:0] taps1x
);

    logic [DATA_WIDTH-1:0] mem [0:2*TAP_DISTANCE-1];

    // Shift one pixel in per enabled clock; storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (clken) begin
            mem[0] <= shiftin;
            for (int i = 1; i < 2 * TAP_DISTANCE; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Taps show the pixel written one line ago and two lines ago
    assign taps1x = mem[TAP_DISTANCE-1];
    assign taps0x = mem[2*TAP_DISTANCE-1];

endmodule

// File: rtl/median_filter.sv
// rtl/median_filter.sv - 3x3 median filter on a framed 8-bit grayscale stream, fixed 4-cycle latency
module median_filter
    import median_filter_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] BORDER_VALUE = '0,
    parameter int                    LINE_WIDTH   = 640
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [DATA_WIDTH-1:0] gray,
    input  logic                  gray_valid,
    input  logic                  gray_hsync,
    input  logic                  gray_vsync,
    output logic [DATA_WIDTH-1:0] median,
    output logic                  median_valid,
    output logic                  median_hsync,
    output logic                  median_vsync
);

    logic [DATA_WIDTH-1:0] taps0x;
    logic [DATA_WIDTH-1:0] taps1x;
    logic                  in_active;

    // win[row][col]: row 0 is two lines up, row 2 is the current line; col 2 is newest
    logic [DATA_WIDTH-1:0] win [0:2][0:2];
    logic [1:0]            col_cnt;
    logic [1:0]            row_cnt;
    logic                  hsync_d;
    logic                  border_s1;
    logic                  border_s2;
    logic                  border_s3;

    logic [DATA_WIDTH-1:0] row_max [0:2];
    logic [DATA_WIDTH-1:0] row_mid [0:2];
    logic [DATA_WIDTH-1:0] row_min [0:2];

    logic [DATA_WIDTH-1:0] max_of_mins;
    logic [DATA_WIDTH-1:0] med_of_mids;
    logic [DATA_WIDTH-1:0] min_of_maxes;

    logic [MEDIAN_LATENCY-1:0] valid_pipe;
    logic [MEDIAN_LATENCY-1:0] hsync_pipe;
    logic [MEDIAN_LATENCY-1:0] vsync_pipe;

    assign in_active = gray_vsync && gray_hsync;

    shift_register_2taps #(
        .DATA_WIDTH  (DATA_WIDTH),
        .TAP_DISTANCE(LINE_WIDTH)
    ) u_line_buffer (
        .clk    (clk),
        .clken  (gray_valid),
        .shiftin(gray),
        .taps0x (taps0x),
        .taps1x (taps1x)
    );

    // Track position inside the frame so the first two rows and columns can be forced to the border value
    always_ff @(posedge clk) begin
        if (reset_p) begin
            col_cnt <= 2'd0;
            row_cnt <= 2'd0;
            hsync_d <= 1'b0;
        end else begin
            hsync_d <= gray_hsync;
            if (!gray_hsync) begin
                col_cnt <= 2'd0;
            end else if (gray_vsync && gray_valid && col_cnt != 2'd2) begin
                col_cnt <= col_cnt + 2'd1;
            end
            if (!gray_vsync) begin
                row_cnt <= 2'd0;
            end else if (hsync_d && !gray_hsync && row_cnt != 2'd2) begin
                row_cnt <= row_cnt + 2'd1;
            end
        end
    end

    // Window stage: shift in a new column per accepted pixel, hold on gaps, clear outside active lines
    always_ff @(posedge clk) begin
        if (reset_p || !in_active) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
            border_s1 <= 1'b0;
        end else if (gray_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= taps0x;
            win[1][2] <= taps1x;
            win[2][2] <= gray;
            border_s1 <= (row_cnt < 2'd2) || (col_cnt < 2'd2);
        end
    end

    // Stage A: order each window row independently
    for (genvar r = 0; r < 3; r++) begin : g_row_sort
        median_filter_sort3 #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_sort3 (
            .clk    (clk),
            .reset_p(reset_p),
            .a      (win[r][0]),
            .b      (win[r][1]),
            .c      (win[r][2]),
            .max_v  (row_max[r]),
            .mid_v  (row_mid[r]),
            .min_v  (row_min[r])
        );
    end

    // Stage B: the median of nine lies between the largest min and smallest max, around the mid of mids
    always_ff @(posedge clk) begin
        if (reset_p) begin
            max_of_mins  <= '0;
            med_of_mids  <= '0;
            min_of_maxes <= '0;
            border_s2    <= 1'b0;
            border_s3    <= 1'b0;
        end else begin
            border_s2    <= border_s1;
            border_s3    <= border_s2;
            max_of_mins  <= DATA_WIDTH'(max3_f(SORT_WIDTH'(row_min[0]), SORT_WIDTH'(row_min[1]),
                                               SORT_WIDTH'(row_min[2])));
            med_of_mids  <= DATA_WIDTH'(med3_f(SORT_WIDTH'(row_mid[0]), SORT_WIDTH'(row_mid[1]),
                                               SORT_WIDTH'(row_mid[2])));
            min_of_maxes <= DATA_WIDTH'(min3_f(SORT_WIDTH'(row_max[0]), SORT_WIDTH'(row_max[1]),
                                               SORT_WIDTH'(row_max[2])));
        end
    end

    // Stage C: final median of the three candidates, replaced by the border value near frame edges
    always_ff @(posedge clk) begin
        if (reset_p) begin
            median <= '0;
        end else if (border_s3) begin
            median <= BORDER_VALUE;
        end else begin
            median <= DATA_WIDTH'(med3_f(SORT_WIDTH'(max_of_mins), SORT_WIDTH'(med_of_mids),
                                         SORT_WIDTH'(min_of_maxes)));
        end
    end

    // Framing signals travel through a delay line matching the data pipeline
    always_ff @(posedge clk) begin
        if (reset_p) begin
            valid_pipe <= '0;
            hsync_pipe <= '0;
            vsync_pipe <= '0;
        end else begin
            valid_pipe <= {valid_pipe[MEDIAN_LATENCY-2:0], gray_valid};
            hsync_pipe <= {hsync_pipe[MEDIAN_LATENCY-2:0], gray_hsync};
            vsync_pipe <= {vsync_pipe[MEDIAN_LATENCY-2:0], gray_vsync};
        end
    end

    assign median_valid = valid_pipe[MEDIAN_LATENCY-1];
    assign median_hsync = hsync_pipe[MEDIAN_LATENCY-1];
    assign median_vsync = vsync_pipe[MEDIAN_LATENCY-1];

endmodule

// File: tb/tb_median_filter.sv
// tb/tb_median_filter.sv - randomized self-checking bench for median_filter against an image-level model
module tb_median_filter;

    localparam int DW = 8;
    localparam int W  = 16;
    localparam int H  = 8;

    logic          clk = 1'b0;
    logic          reset_p;
    logic [DW-1:0] gray;
    logic          gray_valid;
    logic          gray_hsync;
    logic          gray_vsync;
    logic [DW-1:0] median;
    logic          median_valid;
    logic          median_hsync;
    logic          median_vsync;

    always #5 clk = ~clk;

    median_filter #(
        .DATA_WIDTH  (DW),
        .BORDER_VALUE(8'd0),
        .LINE_WIDTH  (W)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .gray        (gray),
        .gray_valid  (gray_valid),
        .gray_hsync  (gray_hsync),
        .gray_vsync  (gray_vsync),
        .median      (median),
        .median_valid(median_valid),
        .median_hsync(median_hsync),
        .median_vsync(median_vsync)
    );

    typedef struct {
        bit          valid;
        bit          hs;
        bit          vs;
        bit          chk_med;
        logic [7:0]  med;
        int          row;
        int          col;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_on = 0;
    bit   chk_en = 1;
    int   first_in_cyc = -1;
    int   first_out_cyc = -1;
    exp_t drv;
    exp_t hist [4];

    logic [7:0] img     [0:H-1][0:W-1];
    logic [7:0] cap     [0:H-1][0:W-1];
    logic [7:0] ref_cap [0:H-1][0:W-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t zero_entry();
        exp_t e;
        e.valid = 0; e.hs = 0; e.vs = 0; e.chk_med = 1; e.med = 8'd0; e.row = -1; e.col = 0;
        return e;
    endfunction

    // Plain median of nine numbers by sorting
    function automatic logic [7:0] med9(input logic [7:0] v [9]);
        logic [7:0] s [9];
        logic [7:0] t;
        s = v;
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
            end
        end
        return s[4];
    endfunction

    // Filtered value for image position (r,c): border region is 0, otherwise median of the 3x3 block ending at (r,c)
    function automatic logic [7:0] expected_pixel(input int r, input int c);
        logic [7:0] v [9];
        if (r < 2 || c < 2) return 8'd0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v[i*3+j] = img[r-2+i][c-2+j];
            end
        end
        return med9(v);
    endfunction

    task automatic drive(input bit v, input bit hs, input bit vs, input logic [7:0] pix,
                         input int r, input int c);
        bit act;
        act = v && hs && vs;
        gray = pix; gray_valid = v; gray_hsync = hs; gray_vsync = vs;
        drv.valid = v; drv.hs = hs; drv.vs = vs;
        drv.chk_med = chk_en && act;
        drv.row = act ? r : -1;
        drv.col = c;
        drv.med = act ? expected_pixel(r, c) : 8'd0;
        if (act && first_in_cyc < 0) first_in_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int rows, input int gap_pct);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) cap[r][c] = 8'hAA;
        repeat (2) drive(0, 0, 1, 8'd0, 0, 0);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                int gaps = 0;
                while (gaps < 3 && $urandom_range(99) < gap_pct) begin
                    drive(0, 1, 1, 8'($urandom), r, c);
                    gaps++;
                end
                drive(1, 1, 1, img[r][c], r, c);
            end
            repeat (3) drive(0, 0, 1, 8'd0, 0, 0);
        end
        repeat (3) drive(0, 0, 0, 8'd0, 0, 0);
    endtask

    task automatic fill_random(input int lo);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(9) == 0) img[r][c] = ($urandom_range(1) != 0) ? 8'd255 : 8'(lo);
                else img[r][c] = 8'($urandom_range(255, lo));
            end
        end
    endtask

    // Record what the inputs sampled at this edge must produce MEDIAN_LATENCY edges later
    always @(posedge clk) begin
        cyc++;
        if (reset_p) begin
            for (int i = 0; i < 4; i++) hist[i] = zero_entry();
        end else begin
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = drv;
        end
    end

    // Compare DUT outputs against the recorded expectation every cycle
    always @(negedge clk) begin
        if (mon_on) begin
            check("median_valid", 32'(median_valid), 32'(hist[3].valid));
            check("median_hsync", 32'(median_hsync), 32'(hist[3].hs));
            check("median_vsync", 32'(median_vsync), 32'(hist[3].vs));
            if (hist[3].chk_med) check("median", 32'(median), 32'(hist[3].med));
            if (hist[3].row >= 0) cap[hist[3].row][hist[3].col] = median;
            if (median_valid && first_out_cyc < 0) first_out_cyc = cyc;
        end
    end

    initial begin
        int cnt;
        reset_p = 1; gray = 0; gray_valid = 0; gray_hsync = 0; gray_vsync = 0;
        drv = zero_entry();
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1;
        check("reset_median", 32'(median), 0);
        check("reset_valid", 32'(median_valid), 0);
        check("reset_hsync", 32'(median_hsync), 0);
        check("reset_vsync", 32'(median_vsync), 0);
        reset_p = 0;
        repeat (2) drive(0, 0, 0, 8'd0, 0, 0);

        // Flat image of 100
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd100;
        first_in_cyc = -1; first_out_cyc = -1;
        send_frame(H, 0);
        check("latency", 32'(first_out_cyc - first_in_cyc), 4);
        check("flat_interior", 32'(cap[4][8]), 100);
        check("flat_last", 32'(cap[7][15]), 100);
        check("flat_border_row", 32'(cap[0][5]), 0);
        check("flat_border_col", 32'(cap[5][1]), 0);

        // Single impulse in a zero field
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd0;
        img[4][5] = 8'd255;
        send_frame(H, 0);
        cnt = 0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) if (cap[r][c] != 8'd0) cnt++;
        check("impulse_nonzero_outputs", 32'(cnt), 0);

        // Known window in the top-left corner, median lands at (2,2)
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd0;
        img[0][0] = 8'd10; img[0][1] = 8'd200; img[0][2] = 8'd30;
        img[1][0] = 8'd40; img[1][1] = 8'd50;  img[1][2] = 8'd60;
        img[2][0] = 8'd70; img[2][1] = 8'd80;  img[2][2] = 8'd90;
        check("model_window", 32'(expected_pixel(2, 2)), 60);
        send_frame(3, 0);
        check("window_median", 32'(cap[2][2]), 60);

        // Same random image with and without valid gaps must filter identically
        fill_random(0);
        send_frame(H, 0);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) ref_cap[r][c] = cap[r][c];
        send_frame(H, 40);
        cnt = 0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) if (cap[r][c] !== ref_cap[r][c]) cnt++;
        check("gap_vs_gapfree_diffs", 32'(cnt), 0);

        // Reset pulse in the middle of a line, then a clean frame
        fill_random(0);
        chk_en = 0;
        repeat (2) drive(0, 0, 1, 8'd0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < W; c++) drive(1, 1, 1, img[r][c], r, c);
            repeat (3) drive(0, 0, 1, 8'd0, 0, 0);
        end
        for (int c = 0; c < 7; c++) drive(1, 1, 1, img[2][c], 2, c);
        reset_p = 1;
        drive(1, 1, 1, img[2][7], 2, 7);
        check("midreset_median", 32'(median), 0);
        check("midreset_valid", 32'(median_valid), 0);
        check("midreset_hsync", 32'(median_hsync), 0);
        check("midreset_vsync", 32'(median_vsync), 0);
        reset_p = 0;
        repeat (3) drive(0, 0, 1, 8'd0, 0, 0);
        repeat (3) drive(0, 0, 0, 8'd0, 0, 0);
        chk_en = 1;
        fill_random(0);
        send_frame(H, 20);

        // Back-to-back frames with nonzero content; border rows of the second must be zero
        fill_random(1);
        send_frame(H, 10);
        fill_random(1);
        send_frame(H, 10);
        cnt = 0;
        for (int r = 0; r < 2; r++) for (int c = 0; c < W; c++) if (cap[r][c] != 8'd0) cnt++;
        for (int r = 2; r < H; r++) for (int c = 0; c < 2; c++) if (cap[r][c] != 8'd0) cnt++;
        check("frame2_border_nonzero", 32'(cnt), 0);
        check("frame2_interior_model", 32'(cap[5][9]), 32'(expected_pixel(5, 9)));

        repeat (4) drive(0, 0, 0, 8'd0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
